ex_issuer: RTL and testbench

Execute-stage sequencer that drains the RS-indexed execute entry table. Each cycle it scans the table's packets, round-robin selects one valid entry, drives it to the functional unit and counts its latency. It captures the result and offers it to the complete stage over a valid/ready handshake. On acceptance it returns `done_idx`/`done_en` so the table clears that slot.

---
 rtl/ex_issuer_if.sv | 80 ++++++++
 rtl/ex_issuer.sv | 128 ++++++++++++
 tb/tb_ex_issuer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_issuer_if.sv
// ex_issuer_if: packet types shared by the execute issuer and its neighbours,
// plus the interface bundling the entry table, functional-unit and
// complete-stage signals.
//
// ex_issuer_pkg
//   IS_EX_PACKET : issue->execute packet (valid, is_mult, inst, NPC)
//   EX_CP_PACKET : execute->complete packet (result, NPC, inst, rs_idx, valid)
//   NOP_PACKET   : idle issue packet (valid=0, inst=NOP, NPC=0)
//
// ex_issuer_if (parameter RS_SZ)
//   ex_entries   : entry table contents, one IS_EX_PACKET per slot
//   fu_result    : functional-unit result for fu_packet
//   cp_ready     : complete stage accepts ex_cp_packet
//   fu_packet    : packet currently executing
//   fu_start     : first execute cycle of fu_packet
//   ex_cp_packet : completed packet offered to the complete stage
//   done_idx     : table slot to clear
//   done_en      : clear strobe for done_idx
//   modport master : issuer side
//   modport slave  : table / functional unit / complete stage side

`ifndef RS_SZ
`define RS_SZ 8
`endif

`ifndef NOP
`define NOP 32'h0000_0013
`endif

package ex_issuer_pkg;

    localparam int RS_IDX_W = (`RS_SZ > 1) ? $clog2(`RS_SZ) : 1;

    typedef struct packed {
        logic        valid;
        logic        is_mult;
        logic [31:0] inst;
        logic [31:0] NPC;
    } IS_EX_PACKET;

    typedef struct packed {
        logic [31:0]         result;
        logic [31:0]         NPC;
        logic [31:0]         inst;
        logic [RS_IDX_W-1:0] rs_idx;
        logic                valid;
    } EX_CP_PACKET;

    localparam IS_EX_PACKET NOP_PACKET = '{valid: 1'b0, is_mult: 1'b0, inst: `NOP, NPC: 32'h0};

endpackage

interface ex_issuer_if
    import ex_issuer_pkg::*;
#(
    parameter int RS_SZ = `RS_SZ
) ();

    localparam int IDX_W = (RS_SZ > 1) ? $clog2(RS_SZ) : 1;

    IS_EX_PACKET [RS_SZ-1:0] ex_entries;
    logic [31:0]             fu_result;
    logic                    cp_ready;
    IS_EX_PACKET             fu_packet;
    logic                    fu_start;
    EX_CP_PACKET             ex_cp_packet;
    logic [IDX_W-1:0]        done_idx;
    logic                    done_en;

    modport master (
        input  ex_entries, fu_result, cp_ready,
        output fu_packet, fu_start, ex_cp_packet, done_idx, done_en
    );

    modport slave (
        output ex_entries, fu_result, cp_ready,
        input  fu_packet, fu_start, ex_cp_packet, done_idx, done_en
    );

endinterface

// File: rtl/ex_issuer.sv
// ex_issuer: execute-stage sequencer. Round-robin picks one valid entry from
// the execute entry table, holds it on the functional unit for its latency
// (1 cycle ALU, MULT_LAT cycles multiply), captures the result and offers it
// to the complete stage. On acceptance it strobes done_en/done_idx so the
// table clears the slot. Only one entry is ever in flight.
//
// Ports
//   clock     : rising-edge clock
//   reset     : synchronous, active-low reset
//   interrupt : synchronous flush, active-high
//   bus       : ex_issuer_if.master (table, functional unit, complete stage)

module ex_issuer
    import ex_issuer_pkg::*;
#(
    parameter int RS_SZ    = `RS_SZ,
    parameter int MULT_LAT = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      interrupt,
    ex_issuer_if.master bus
);

    localparam int IDX_W = (RS_SZ > 1) ? $clog2(RS_SZ) : 1;
    localparam int CNT_W = $clog2(MULT_LAT) + 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  cur_idx;
    IS_EX_PACKET       cur_pkt;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       res;
    logic              start;

    logic              found;
    logic [IDX_W-1:0]  sel;

    // First valid slot scanning ptr, ptr+1, ... with wrap-around.
    always_comb begin
        int j;
        j     = 0;
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < RS_SZ; i++) begin
            j = (int'(ptr) + i) % RS_SZ;
            if (!found && bus.ex_entries[j].valid) begin
                found = 1'b1;
                sel   = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            res     <= '0;
            cur_idx <= '0;
            cur_pkt <= NOP_PACKET;
            start   <= 1'b0;
        end else if (interrupt) begin
            // Flush drops the in-flight entry without clearing its slot.
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            res     <= '0;
            cur_idx <= '0;
            cur_pkt <= NOP_PACKET;
            start   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    start <= 1'b0;
                    if (found) begin
                        cur_idx <= sel;
                        cur_pkt <= bus.ex_entries[sel];
                        ptr     <= (sel == IDX_W'(RS_SZ - 1)) ? '0 : sel + IDX_W'(1);
                        cnt     <= bus.ex_entries[sel].is_mult ? CNT_W'(MULT_LAT) : CNT_W'(1);
                        start   <= 1'b1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    start <= 1'b0;
                    if (cnt == CNT_W'(1)) begin
                        res   <= bus.fu_result;
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    start <= 1'b0;
                    if (bus.cp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    start <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.fu_packet = (state == EXEC) ? cur_pkt : NOP_PACKET;
    assign bus.fu_start  = start;

    // Acceptance strobe; suppressed when the same edge resets or flushes.
    assign bus.done_en  = (state == DONE) && bus.cp_ready && reset && !interrupt;
    assign bus.done_idx = bus.done_en ? cur_idx : '0;

    always_comb begin
        bus.ex_cp_packet = '0;
        if (state == DONE) begin
            bus.ex_cp_packet.result = res;
            bus.ex_cp_packet.NPC    = cur_pkt.NPC;
            bus.ex_cp_packet.inst   = cur_pkt.inst;
            bus.ex_cp_packet.rs_idx = RS_IDX_W'(cur_idx);
            bus.ex_cp_packet.valid  = 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_issuer.sv
// tb_ex_issuer: directed self-checking bench for ex_issuer (RS_SZ=8,
// MULT_LAT=4). The bench plays the entry table: it clears a slot after each
// done_en cycle.

`timescale 1ns/1ps

module tb_ex_issuer;
    import ex_issuer_pkg::*;

    logic clock;
    logic reset;
    logic interrupt;

    int passed;
    int total;

    ex_issuer_if #(.RS_SZ(8)) bus ();

    ex_issuer #(.RS_SZ(8), .MULT_LAT(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .interrupt (interrupt),
        .bus       (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic IS_EX_PACKET mk(input logic [31:0] inst, input logic [31:0] npc, input logic mult);
        IS_EX_PACKET p;
        p.valid   = 1'b1;
        p.is_mult = mult;
        p.inst    = inst;
        p.NPC     = npc;
        return p;
    endfunction

    // One clock cycle; emulates the table clearing the accepted slot.
    task automatic tick();
        logic       de;
        logic [2:0] di;
        #1;
        de = bus.done_en;
        di = bus.done_idx;
        @(posedge clock);
        @(negedge clock);
        if (de) bus.ex_entries[di].valid = 1'b0;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        interrupt     = 1'b0;
        bus.cp_ready  = 1'b1;
        bus.fu_result = 32'h0;
        bus.ex_entries = '0;
        bus.ex_entries[0] = mk(32'h00A0_0001, 32'h0000_0100, 1'b0);
        bus.ex_entries[3] = mk(32'h00A0_0003, 32'h0000_010C, 1'b0);
        tick();
        tick();
        #1;
        total++; if (bus.done_en !== 1'b0) $display("FAIL reset_done_en: got %0b want 0", bus.done_en); else passed++;
        total++; if (bus.done_idx !== 3'd0) $display("FAIL reset_done_idx: got %0d want 0", bus.done_idx); else passed++;
        total++; if (bus.fu_start !== 1'b0) $display("FAIL reset_fu_start: got %0b want 0", bus.fu_start); else passed++;
        total++; if (bus.fu_packet !== NOP_PACKET) $display("FAIL reset_fu_packet: got %h want %h", bus.fu_packet, NOP_PACKET); else passed++;
        total++; if (bus.ex_cp_packet !== EX_CP_PACKET'(0)) $display("FAIL reset_cp_packet: got %h want 0", bus.ex_cp_packet); else passed++;
        // First released cycle selects entry 0.
        reset = 1'b1;
        tick();
        #1;
        total++; if (bus.fu_start !== 1'b1) $display("FAIL first_fu_start: got %0b want 1", bus.fu_start); else passed++;
        total++; if (bus.fu_packet.inst !== 32'h00A0_0001) $display("FAIL first_fu_inst: got %h want 00a00001", bus.fu_packet.inst); else passed++;
        bus.fu_result = 32'h1234_5678;
        tick();
        #1;
        total++; if (bus.done_en !== 1'b1) $display("FAIL first_done_en: got %0b want 1", bus.done_en); else passed++;
        total++; if (bus.done_idx !== 3'd0) $display("FAIL first_done_idx: got %0d want 0", bus.done_idx); else passed++;
        total++; if (bus.ex_cp_packet.result !== 32'h1234_5678) $display("FAIL first_result: got %h want 12345678", bus.ex_cp_packet.result); else passed++;
        total++; if (bus.ex_cp_packet.NPC !== 32'h0000_0100) $display("FAIL first_npc: got %h want 00000100", bus.ex_cp_packet.NPC); else passed++;
        tick();
        tick();
        tick();
        #1;
        total++; if (bus.done_en !== 1'b1 || bus.done_idx !== 3'd3) $display("FAIL second_done: got en=%0b idx=%0d want en=1 idx=3", bus.done_en, bus.done_idx); else passed++;
        tick();
        tick();
        #1;
        total++; if (bus.fu_packet.valid !== 1'b0 || bus.fu_start !== 1'b0) $display("FAIL empty_idle: got valid=%0b start=%0b want 0 0", bus.fu_packet.valid, bus.fu_start); else passed++;
    endtask

    task automatic test_round_robin();
        int idxs[$];
        int cycs[$];
        reset = 1'b0;
        bus.ex_entries = '0;
        tick();
        reset = 1'b1;
        bus.cp_ready = 1'b1;
        bus.ex_entries[1] = mk(32'h00B0_0001, 32'h0000_0204, 1'b0);
        bus.ex_entries[2] = mk(32'h00B0_0002, 32'h0000_0208, 1'b0);
        bus.ex_entries[5] = mk(32'h00B0_0005, 32'h0000_0214, 1'b0);
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.done_en === 1'b1) begin
                idxs.push_back(int'(bus.done_idx));
                cycs.push_back(c);
            end
            tick();
        end
        total++; if (idxs.size() != 3) $display("FAIL rr_count: got %0d want 3", idxs.size()); else passed++;
        if (idxs.size() == 3) begin
            total++; if (idxs[0] != 1 || idxs[1] != 2 || idxs[2] != 5) $display("FAIL rr_order: got %0d,%0d,%0d want 1,2,5", idxs[0], idxs[1], idxs[2]); else passed++;
            total++; if (cycs[1] - cycs[0] != 3 || cycs[2] - cycs[1] != 3) $display("FAIL rr_spacing: got %0d,%0d want 3,3", cycs[1] - cycs[0], cycs[2] - cycs[1]); else passed++;
        end
        total++; if (dut.ptr !== 3'd6) $display("FAIL rr_ptr: got %0d want 6", dut.ptr); else passed++;
    endtask

    task automatic test_wrap();
        int  idxs[$];
        logic refilled;
        refilled = 1'b0;
        bus.ex_entries[7] = mk(32'h00C0_0007, 32'h0000_031C, 1'b0);
        bus.ex_entries[0] = mk(32'h00C0_0000, 32'h0000_0300, 1'b0);
        for (int c = 0; c < 16; c++) begin
            #1;
            if (idxs.size() == 2 && !refilled) begin
                bus.ex_entries[0] = mk(32'h00C1_0000, 32'h0000_0300, 1'b0);
                bus.ex_entries[7] = mk(32'h00C1_0007, 32'h0000_031C, 1'b0);
                refilled = 1'b1;
            end
            if (bus.done_en === 1'b1) idxs.push_back(int'(bus.done_idx));
            tick();
        end
        total++; if (idxs.size() != 4) $display("FAIL wrap_count: got %0d want 4", idxs.size()); else passed++;
        if (idxs.size() == 4) begin
            total++; if (idxs[0] != 7 || idxs[1] != 0 || idxs[2] != 7 || idxs[3] != 0) $display("FAIL wrap_order: got %0d,%0d,%0d,%0d want 7,0,7,0", idxs[0], idxs[1], idxs[2], idxs[3]); else passed++;
        end
    endtask

    task automatic test_mult();
        int          starts;
        int          execs;
        int          dones;
        logic [31:0] res_seen;
        logic [2:0]  rs_seen;
        logic [2:0]  idx_seen;
        starts = 0; execs = 0; dones = 0;
        res_seen = '0; rs_seen = '0; idx_seen = '0;
        bus.cp_ready = 1'b1;
        bus.ex_entries[4] = mk(32'h0200_0033, 32'h0000_0410, 1'b1);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.fu_start === 1'b1) starts++;
            if (bus.fu_packet.valid === 1'b1) execs++;
            bus.fu_result = (bus.fu_packet.valid === 1'b1 && execs == 4) ? 32'hDEAD_BEEF : 32'h0BAD_0000 + 32'(c);
            if (bus.done_en === 1'b1) begin
                dones++;
                res_seen = bus.ex_cp_packet.result;
                rs_seen  = bus.ex_cp_packet.rs_idx;
                idx_seen = bus.done_idx;
            end
            tick();
        end
        total++; if (starts != 1) $display("FAIL mult_starts: got %0d want 1", starts); else passed++;
        total++; if (execs != 4) $display("FAIL mult_exec_cycles: got %0d want 4", execs); else passed++;
        total++; if (dones != 1) $display("FAIL mult_dones: got %0d want 1", dones); else passed++;
        total++; if (res_seen !== 32'hDEAD_BEEF) $display("FAIL mult_result: got %h want deadbeef", res_seen); else passed++;
        total++; if (rs_seen !== 3'd4 || idx_seen !== 3'd4) $display("FAIL mult_idx: got rs=%0d done=%0d want 4 4", rs_seen, idx_seen); else passed++;
    endtask

    task automatic test_stall();
        EX_CP_PACKET snap;
        logic        seen;
        logic        stable;
        int          extra_de;
        int          extra_st;
        seen = 1'b0; stable = 1'b1; extra_de = 0; extra_st = 0;
        bus.cp_ready = 1'b0;
        bus.fu_result = 32'h0000_5A5A;
        bus.ex_entries[6] = mk(32'h00D0_0006, 32'h0000_0518, 1'b0);
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (bus.ex_cp_packet.valid === 1'b1) seen = 1'b1;
            else tick();
        end
        total++; if (!seen) $display("FAIL stall_reach_done: got timeout want valid packet"); else passed++;
        snap = bus.ex_cp_packet;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (bus.ex_cp_packet !== snap) stable = 1'b0;
            if (bus.done_en !== 1'b0) extra_de++;
            tick();
        end
        total++; if (!stable) $display("FAIL stall_stable: got changed packet %h want %h", bus.ex_cp_packet, snap); else passed++;
        total++; if (extra_de != 0) $display("FAIL stall_done_en: got %0d pulses want 0", extra_de); else passed++;
        total++; if (snap.rs_idx !== 3'd6 || snap.result !== 32'h0000_5A5A) $display("FAIL stall_fields: got rs=%0d res=%h want 6 00005a5a", snap.rs_idx, snap.result); else passed++;
        bus.cp_ready = 1'b1;
        #1;
        total++; if (bus.done_en !== 1'b1 || bus.done_idx !== 3'd6) $display("FAIL stall_accept: got en=%0b idx=%0d want 1 6", bus.done_en, bus.done_idx); else passed++;
        tick();
        for (int k = 0; k < 10; k++) begin
            #1;
            if (bus.done_en === 1'b1) extra_de++;
            if (bus.fu_start === 1'b1) extra_st++;
            tick();
        end
        total++; if (extra_de != 0 || extra_st != 0) $display("FAIL stall_reissue: got de=%0d start=%0d want 0 0", extra_de, extra_st); else passed++;
    endtask

    task automatic test_interrupt();
        logic seen;
        seen = 1'b0;
        bus.cp_ready = 1'b1;
        bus.ex_entries[2] = mk(32'h0200_0233, 32'h0000_0608, 1'b1);
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (bus.fu_start === 1'b1) seen = 1'b1;
            else tick();
        end
        total++; if (!seen) $display("FAIL int_reach_exec: got timeout want fu_start"); else passed++;
        tick();
        interrupt = 1'b1;
        tick();
        interrupt = 1'b0;
        #1;
        total++; if (bus.fu_packet.valid !== 1'b0 || bus.ex_cp_packet.valid !== 1'b0 || bus.done_en !== 1'b0) $display("FAIL int_exec_idle: got fu=%0b cp=%0b de=%0b want 0 0 0", bus.fu_packet.valid, bus.ex_cp_packet.valid, bus.done_en); else passed++;
        total++; if (dut.ptr !== 3'd0) $display("FAIL int_exec_ptr: got %0d want 0", dut.ptr); else passed++;
        // Entry 2 was never cleared, so it is reissued; flush it again in DONE.
        bus.cp_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (bus.ex_cp_packet.valid === 1'b1) seen = 1'b1;
            else tick();
        end
        total++; if (!seen) $display("FAIL int_reach_done: got timeout want valid packet"); else passed++;
        bus.cp_ready = 1'b1;
        interrupt = 1'b1;
        #1;
        total++; if (bus.done_en !== 1'b0) $display("FAIL int_done_en: got %0b want 0", bus.done_en); else passed++;
        tick();
        interrupt = 1'b0;
        bus.cp_ready = 1'b0;
        #1;
        total++; if (bus.ex_cp_packet.valid !== 1'b0 || bus.done_en !== 1'b0 || bus.fu_packet.valid !== 1'b0) $display("FAIL int_done_idle: got cp=%0b de=%0b fu=%0b want 0 0 0", bus.ex_cp_packet.valid, bus.done_en, bus.fu_packet.valid); else passed++;
        total++; if (dut.ptr !== 3'd0) $display("FAIL int_done_ptr: got %0d want 0", dut.ptr); else passed++;
        total++; if (bus.ex_entries[2].valid !== 1'b1) $display("FAIL int_slot_kept: got %0b want 1", bus.ex_entries[2].valid); else passed++;
        bus.ex_entries = '0;
        tick();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset = 1'b0;
        interrupt = 1'b0;
        bus.cp_ready = 1'b0;
        bus.fu_result = 32'h0;
        bus.ex_entries = '0;
        @(negedge clock);
        test_reset();
        test_round_robin();
        test_wrap();
        test_mult();
        test_stall();
        test_interrupt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
